// File: rtl/ksa_share_ctrl_if.sv
// Requester/response bundle between user-project request logic and the shared adder controller.
// Latency: none, wires only.
// Backpressure: req_ready_o grants one requester at a time; rsp_ready_i stalls the response.
//
// Ports (slave = controller side):
//   req_valid_i[r], req_ready_o[r]     per-requester handshake, at most one ready bit high
//   req_a{r}_i, req_b{r}_i             operands, W*NW bits each
//   req_nw{r}_i                        word count minus one
//   req_cin_i[r]                       initial carry-in
//   rsp_valid_o, rsp_ready_i           response handshake
//   rsp_id_o, rsp_sum_o, rsp_cout_o    response payload
interface ksa_share_ctrl_if #(
  parameter int W  = 16,
  parameter int NW = 4
);
  localparam int OPW = W * NW;
  localparam int IW  = $clog2(NW);

  logic [1:0]     req_valid_i;
  logic [1:0]     req_ready_o;
  logic [OPW-1:0] req_a0_i;
  logic [OPW-1:0] req_b0_i;
  logic [OPW-1:0] req_a1_i;
  logic [OPW-1:0] req_b1_i;
  logic [IW-1:0]  req_nw0_i;
  logic [IW-1:0]  req_nw1_i;
  logic [1:0]     req_cin_i;

  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic           rsp_id_o;
  logic [OPW-1:0] rsp_sum_o;
  logic           rsp_cout_o;

  // Controller side.
  modport slave (
    input  req_valid_i, req_a0_i, req_b0_i, req_a1_i, req_b1_i,
           req_nw0_i, req_nw1_i, req_cin_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_cout_o
  );

  // Requester/consumer side.
  modport master (
    output req_valid_i, req_a0_i, req_b0_i, req_a1_i, req_b1_i,
           req_nw0_i, req_nw1_i, req_cin_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_cout_o
  );
endinterface

// File: rtl/ksa_share_ctrl.sv
// Two-requester round-robin sequencer for one shared W-bit adder slice, LS word first.
// Latency: response valid nw+2 cycles after the request handshake (2 for one word, 5 for four).
// Backpressure: one transaction in flight; no request accepted until the response is taken.
//
// Ports:
//   wb_clk_i, wb_rst_ni    clock, asynchronous active-low reset
//   bus (slave)            request/response bundle, see ksa_share_ctrl_if
//   add_a_o, add_b_o       operand words to the adder slice (zero outside RUN)
//   add_cin_o              carry into the adder slice (zero outside RUN)
//   add_sum_i, add_cout_i  combinational adder slice result
//   busy_o                 high whenever a transaction is in progress
module ksa_share_ctrl #(
  parameter int W  = 16,
  parameter int NW = 4
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  ksa_share_ctrl_if.slave bus,
  output logic [W-1:0] add_a_o,
  output logic [W-1:0] add_b_o,
  output logic         add_cin_o,
  input  logic [W-1:0] add_sum_i,
  input  logic         add_cout_i,
  output logic         busy_o
);

  localparam int OPW = W * NW;
  localparam int IW  = $clog2(NW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Captured request; operand bits above word nw are kept but never selected.
  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [IW-1:0]  nw;
  } op_t;

  logic [1:0]     state_q, state_d;
  op_t            op_q, op_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [OPW-1:0] sum_q, sum_d;
  logic           id_q, id_d;
  logic           last_q, last_d;

  logic [1:0]     grant;
  logic           gnt_id;
  logic           run;

  // Arbitration is only live in IDLE. The reset term keeps ready low while
  // reset is held even though the FSM already sits in IDLE.
  always_comb begin
    grant = 2'b00;
    if ((state_q == S_IDLE) && wb_rst_ni) begin
      case (bus.req_valid_i)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Contention: the requester that did not win last time goes now.
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign gnt_id          = grant[1];
  assign bus.req_ready_o = grant;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    id_d    = id_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          op_d.a  = gnt_id ? bus.req_a1_i  : bus.req_a0_i;
          op_d.b  = gnt_id ? bus.req_b1_i  : bus.req_b0_i;
          op_d.nw = gnt_id ? bus.req_nw1_i : bus.req_nw0_i;
          carry_d = bus.req_cin_i[gnt_id];
          idx_d   = '0;
          sum_d   = '0;
          id_d    = gnt_id;
          last_d  = gnt_id;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // One word per cycle; the slice carry is chained through carry_q.
        sum_d[W*idx_q +: W] = add_sum_i;
        carry_d             = add_cout_i;
        if (idx_q == op_q.nw) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      id_q    <= 1'b0;
      // Pointing at requester 1 lets requester 0 win the first contention.
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Adder slice drive; gated to zero so idle cycles present no stale operands.
  assign run       = (state_q == S_RUN);
  assign add_a_o   = run ? op_q.a[W*idx_q +: W] : '0;
  assign add_b_o   = run ? op_q.b[W*idx_q +: W] : '0;
  assign add_cin_o = run ? carry_q : 1'b0;

  // Response: carry_q holds the carry out of the top active word once in DONE.
  assign bus.rsp_valid_o = (state_q == S_DONE);
  assign bus.rsp_sum_o   = sum_q;
  assign bus.rsp_cout_o  = carry_q;
  assign bus.rsp_id_o    = id_q;
  assign busy_o          = (state_q != S_IDLE);

  // Grant is mutually exclusive and only ever given while idle.
  a_grant_onehot: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
    bus.req_ready_o != 2'b11);
  a_grant_idle: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
    (|bus.req_ready_o) |-> !busy_o);

endmodule

// File: doc/ksa_share_ctrl.md
# ksa_share_ctrl

Sequencer and two-port round-robin arbiter for one shared 16-bit Kogge-Stone adder slice with carry-in. Each requester submits a 16/32/48/64-bit add. The controller feeds the slice one 16-bit word per cycle, least-significant word first, chaining the carry through a register. It returns the assembled sum and carry-out on a single valid/ready response port tagged with the requester ID. It sits between user-project request logic (LA/Wishbone-driven) and the adder datapath.

## Interface
- W, 16, adder slice width in bits
- NW, 4, maximum words per transaction; operand width is W*NW

- wb_clk_i  in  1  clock; all state updates on the rising edge
- wb_rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  2  per-requester request valid; bit r belongs to requester r
- req_ready_o  out  2  per-requester accept; at most one bit high
- req_a0_i, req_b0_i  in  64 each  requester 0 operands
- req_a1_i, req_b1_i  in  64 each  requester 1 operands
- req_nw0_i, req_nw1_i  in  2 each  word count minus 1 (0 = 16-bit add, 3 = 64-bit add)
- req_cin_i  in  2  per-requester initial carry-in
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_id_o  out  1  requester that owns the response
- rsp_sum_o  out  64  sum; words at index > nw are zero
- rsp_cout_o  out  1  carry out of the top active word
- add_a_o, add_b_o  out  16 each  operand words driven to the adder slice
- add_cin_o  out  1  carry-in driven to the adder slice
- add_sum_i  in  16  adder slice sum (combinational, same cycle)
- add_cout_i  in  1  adder slice carry-out (combinational, same cycle)
- busy_o  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: all registers cleared; rsp_valid_o=0, req_ready_o=0, busy_o=0, rsp_sum_o=0, rsp_cout_o=0, rsp_id_o=0, add_* outputs=0; last-grant pointer=1, so requester 0 wins the first contention.
- IDLE:
  - req_ready_o is combinational, asserted only here.
  - If exactly one req_valid_i bit is high, that requester is granted.
  - If both are high, the requester not equal to last-grant is granted.
  - On grant: capture a, b, nw and cin for the granted requester; set idx=0, carry=cin, clear the sum register, record the ID, update last-grant; move to RUN.
- RUN:
  - Drive add_a_o=a[16*idx+:16], add_b_o=b[16*idx+:16], add_cin_o=carry.
  - Each cycle: sum word idx <= add_sum_i, carry <= add_cout_i.
  - If idx==nw, go to DONE; otherwise idx++.
- DONE:
  - rsp_valid_o=1, with sum, cout and ID stable.
  - Hold until rsp_ready_i=1, then go to IDLE.
- add_a_o, add_b_o and add_cin_o are 0 outside RUN.
- Operand bits above word nw are ignored and never reach the adder.
- Arithmetic: the result equals (a mod 2^(16(nw+1))) + (b mod 2^(16(nw+1))) + cin. rsp_cout_o is bit 16(nw+1) of that value.
- Reset mid-transaction: the FSM returns to IDLE immediately. The transaction is dropped, no response is produced, and requesters must resubmit.
- A request that stays valid across a not-ready cycle must hold stable operands (requester obligation; not checked).

## Timing
- Handshake at cycle T (valid and ready both high in IDLE).
- RUN occupies T+1 through T+1+nw.
- rsp_valid_o rises at T+2+nw: latency 2 cycles for 16-bit, 5 cycles for 64-bit.
- Response handshake at cycle R; IDLE at R+1. The earliest next accept is R+1, when req_ready_o may rise combinationally.
- Peak throughput: one n-word transaction per n+2 cycles.
- rsp_valid_o=1 with rsp_ready_i=1 in the same first cycle completes in one cycle.
- Arbitration and the last-grant update happen only on an accept cycle, never while busy.

## Test plan
- Single-word, requester 0: a=0xFFFF, b=0x0001, nw=0, cin=0 -> rsp_sum=0x0000, cout=1, id=0, rsp_valid exactly 2 cycles after accept.
- Full-width carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, nw=3 -> sum=0, cout=1, latency 5, add_cin_o=1 in RUN cycles 2-4.
- Width masking: nw=1, a=0xDEAD_0000_8000_8000, b=0xBEEF_0000_8000_8000, cin=1 -> sum=0x0000_0000_0001_0001, cout=1; add_a_o never shows 0xDEAD.
- Contention: both requesters valid continuously -> grants alternate 0,1,0,1; req_ready_o is never high for both; rsp_id_o matches each grant.
- Backpressure: hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o and data stay stable, no new accept, busy_o=1; release -> IDLE the next cycle.
- Reset mid-RUN: deassert wb_rst_ni asynchronously during idx=1 of a 64-bit add -> all outputs go to 0 immediately, no response ever; after release, requester 0 wins under contention.
